// File: rtl/div_pkg.sv
// Shared types and helpers for the multi-cycle restoring divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;

  localparam int DIV_WIDTH = 32;

  // Iteration counter width; it only ever needs to reach WIDTH-1.
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/adder_sub.sv
// Ripple-free adder/subtractor: op_in=1 computes a_in - b_in, cb_out is carry (1 = no borrow).
module adder_sub #(
  parameter int WIDTH = 33
) (
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             op_in,
  output logic [WIDTH-1:0] sum_out,
  output logic             cb_out
);

  logic [WIDTH-1:0] b_eff;

  assign b_eff = b_in ^ {WIDTH{op_in}};
  assign {cb_out, sum_out} = {1'b0, a_in} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op_in};

endmodule

// File: rtl/div_unit.sv
// Restoring shift-subtract divider for DIV/DIVU: one quotient bit per cycle,
// operands held as magnitudes, sign fix-up applied in a single FIX cycle.
import div_pkg::*;

module div_unit #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock_in,
  input  logic             reset_in,
  input  logic             start_in,
  input  logic             signed_in,
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] quotient_out,
  output logic [WIDTH-1:0] remainder_out,
  output logic             div0_out
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_t state, state_nx;

  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] dvd_q, dsr_q;
  logic [CW-1:0]    cnt_q;
  logic             qneg_q, rneg_q, div0_q;

  logic             accept;
  logic [WIDTH:0]   shifted, diff;
  logic             no_borrow;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             rem_top_unused;

  assign accept   = start_in & (state == IDLE || state == DONE);
  assign busy_out = (state == CALC) || (state == FIX);
  assign done_out = (state == DONE);

  // The most-negative value negates to itself, which read unsigned is 2^(WIDTH-1).
  assign mag_a = (signed_in & dividend_in[WIDTH-1]) ? -dividend_in : dividend_in;
  assign mag_b = (signed_in & divisor_in[WIDTH-1])  ? -divisor_in  : divisor_in;

  assign shifted        = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
  assign rem_top_unused = rem_q[WIDTH];

  adder_sub #(.WIDTH(WIDTH + 1)) u_trial (
    .a_in   (shifted),
    .b_in   ({1'b0, dsr_q}),
    .op_in  (1'b1),
    .sum_out(diff),
    .cb_out (no_borrow)
  );

  always_ff @(posedge clock_in) begin
    if (reset_in) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start_in) state_nx = CALC;
      CALC:    if (cnt_q == LAST) state_nx = FIX;
      FIX:     state_nx = DONE;
      DONE:    state_nx = start_in ? CALC : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      rem_q         <= '0;
      dvd_q         <= '0;
      dsr_q         <= '0;
      cnt_q         <= '0;
      qneg_q        <= 1'b0;
      rneg_q        <= 1'b0;
      div0_q        <= 1'b0;
      quotient_out  <= '0;
      remainder_out <= '0;
      div0_out      <= 1'b0;
    end else if (accept) begin
      rem_q  <= '0;
      dvd_q  <= mag_a;
      dsr_q  <= mag_b;
      cnt_q  <= '0;
      qneg_q <= signed_in & (dividend_in[WIDTH-1] ^ divisor_in[WIDTH-1]);
      rneg_q <= signed_in & dividend_in[WIDTH-1];
      div0_q <= (divisor_in == '0);
    end else if (state == CALC) begin
      rem_q <= no_borrow ? diff : shifted;
      dvd_q <= {dvd_q[WIDTH-2:0], no_borrow};
      cnt_q <= cnt_q + CW'(1);
    end else if (state == FIX) begin
      // On divide-by-zero the remainder is |dividend|; re-applying the dividend
      // sign restores the raw operand, so only the quotient fix is suppressed.
      quotient_out  <= (qneg_q & ~div0_q) ? -dvd_q : dvd_q;
      remainder_out <= rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
      div0_out      <= div0_q;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit (WIDTH=32) with hand-computed results.
module tb_div_unit;

  logic        clock_in, reset_in, start_in, signed_in;
  logic [31:0] dividend_in, divisor_in;
  logic        busy_out, done_out, div0_out;
  logic [31:0] quotient_out, remainder_out;

  int checks = 0;
  int failures = 0;
  int lat, bcnt;

  div_unit #(.WIDTH(32)) dut (
    .clock_in     (clock_in),
    .reset_in     (reset_in),
    .start_in     (start_in),
    .signed_in    (signed_in),
    .dividend_in  (dividend_in),
    .divisor_in   (divisor_in),
    .busy_out     (busy_out),
    .done_out     (done_out),
    .quotient_out (quotient_out),
    .remainder_out(remainder_out),
    .div0_out     (div0_out)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; start is seen by the next rising edge.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    start_in    = 1'b1;
    signed_in   = s;
    dividend_in = a;
    divisor_in  = b;
    @(posedge clock_in);
    #1 start_in = 1'b0;
  endtask

  task automatic wait_done(output int n, output int busy_n);
    n = 0;
    busy_n = 0;
    forever begin
      @(negedge clock_in);
      n++;
      if (busy_out) busy_n++;
      if (done_out) break;
      if (n > 100) begin
        chk("done_timeout", 64'(n), 64'd34);
        break;
      end
    end
  endtask

  task automatic run_div(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] q, input logic [31:0] r, input logic d0);
    issue(s, a, b);
    wait_done(lat, bcnt);
    chk({tag, "_lat"}, 64'(lat), 64'd34);
    chk({tag, "_busy"}, 64'(bcnt), 64'd33);
    chk({tag, "_q"}, 64'(quotient_out), 64'(q));
    chk({tag, "_r"}, 64'(remainder_out), 64'(r));
    chk({tag, "_d0"}, 64'(div0_out), 64'(d0));
    @(negedge clock_in);
    chk({tag, "_pulse"}, 64'(done_out), 64'd0);
  endtask

  initial begin
    reset_in = 1'b1;
    start_in = 1'b0;
    signed_in = 1'b0;
    dividend_in = '0;
    divisor_in = '0;
    repeat (3) @(negedge clock_in);
    chk("rst_busy", 64'(busy_out), 64'd0);
    chk("rst_done", 64'(done_out), 64'd0);
    chk("rst_q", 64'(quotient_out), 64'd0);
    chk("rst_r", 64'(remainder_out), 64'd0);
    chk("rst_d0", 64'(div0_out), 64'd0);
    reset_in = 1'b0;
    @(negedge clock_in);

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    run_div("div_m100_7", 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
    run_div("div_100_m7", 1'b1, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 1'b0);
    run_div("div_m100_m7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE, 1'b0);
    run_div("divu_7_100", 1'b0, 32'd7, 32'd100, 32'd0, 32'd7, 1'b0);
    run_div("div0_s", 1'b1, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1'b1);
    run_div("div0_u", 1'b0, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1'b1);
    run_div("div0_neg", 1'b1, 32'h80000001, 32'd0, 32'hFFFFFFFF, 32'h80000001, 1'b1);
    run_div("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0);
    run_div("divu_ovf", 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0);

    // Start pulsed mid-CALC must be ignored.
    issue(1'b0, 32'd1000, 32'd10);
    repeat (5) @(negedge clock_in);
    chk("mid_busy", 64'(busy_out), 64'd1);
    issue(1'b0, 32'd50, 32'd5);
    wait_done(lat, bcnt);
    chk("mid_lat", 64'(lat), 64'd29);
    chk("mid_q", 64'(quotient_out), 64'd100);
    chk("mid_r", 64'(remainder_out), 64'd0);

    // Back-to-back: start in the DONE cycle.
    issue(1'b1, 32'hFFFFFF9C, 32'd7);
    wait_done(lat, bcnt);
    chk("b2b_lat", 64'(lat), 64'd34);
    chk("b2b_q", 64'(quotient_out), 64'hFFFFFFF2);
    chk("b2b_r", 64'(remainder_out), 64'hFFFFFFFE);
    @(negedge clock_in);

    // Reset mid-CALC clears everything.
    issue(1'b0, 32'd77, 32'd3);
    repeat (6) @(negedge clock_in);
    reset_in = 1'b1;
    @(posedge clock_in);
    #1 reset_in = 1'b0;
    chk("mrst_busy", 64'(busy_out), 64'd0);
    chk("mrst_done", 64'(done_out), 64'd0);
    chk("mrst_q", 64'(quotient_out), 64'd0);
    chk("mrst_r", 64'(remainder_out), 64'd0);
    chk("mrst_d0", 64'(div0_out), 64'd0);
    @(negedge clock_in);
    chk("mrst_idle", 64'(busy_out), 64'd0);
    run_div("post_rst", 1'b0, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'hF, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
